// File: rtl/alu_exec_unit.sv
// Execute-stage datapath: ALU-control decoder, 32-bit ALU, PC+4 and branch-target adders,
// plus the registered V/Z/N status flags. Optional NOR operation enabled by `ALU_NOR_EN.
module alu_exec_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  aluop,
    input  logic [3:0]  funct,
    input  logic [5:0]  opcode,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] pc,
    input  logic [15:0] imm16,
    output logic [2:0]  gout,
    output logic [31:0] result,
    output logic        zout,
    output logic        vout,
    output logic        nout,
    output logic [31:0] pc_plus4,
    output logic [31:0] branch_target,
    output logic        v_flag,
    output logic        z_flag,
    output logic        n_flag
);

    logic [31:0] sum;
    logic [31:0] diff;
    logic        ovf_add;
    logic        ovf_sub;
    logic [2:0]  flags_d;
    logic [2:0]  flags_q;

    always_comb begin
        gout = 3'b010;
        unique case (aluop)
            2'b00: gout = 3'b010;
            2'b01: gout = 3'b110;
            2'b10: begin
                unique case (funct)
                    4'b0000: gout = 3'b010;
                    4'b0010: gout = 3'b110;
                    4'b0100: gout = 3'b000;
                    4'b0101: gout = 3'b001;
                    4'b1010: gout = 3'b111;
`ifdef ALU_NOR_EN
                    4'b0111: gout = 3'b100;
`endif
                    default: gout = 3'b010;
                endcase
            end
            default: begin
                unique case (opcode)
                    6'b001101: gout = 3'b001;
                    6'b001100: gout = 3'b000;
                    default:   gout = 3'b010;
                endcase
            end
        endcase
    end

    assign sum     = a + b;
    assign diff    = a - b;
    assign ovf_add = (a[31] == b[31]) && (sum[31] != a[31]);
    assign ovf_sub = (a[31] != b[31]) && (diff[31] != a[31]);

    always_comb begin
        result = 32'h0;
        vout   = 1'b0;
        unique case (gout)
            3'b000: result = a & b;
            3'b001: result = a | b;
            3'b010: begin
                result = sum;
                vout   = ovf_add;
            end
            3'b110: begin
                result = diff;
                vout   = ovf_sub;
            end
`ifdef ALU_NOR_EN
            3'b100: result = ~(a | b);
`endif
            // Signed compare: sign of the difference corrected by overflow.
            3'b111: result = {31'b0, diff[31] ^ ovf_sub};
            default: result = 32'h0;
        endcase
    end

    assign zout = (result == 32'h0);
    assign nout = result[31];

    assign pc_plus4      = pc + 32'd4;
    assign branch_target = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        flags_d = {vout, zout, nout};
        if (reset) begin
            flags_d = 3'b000;
        end
    end

    always_ff @(posedge clk) begin
        flags_q <= flags_d;
    end

    assign {v_flag, z_flag, n_flag} = flags_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: a stimulus process pushes model predictions into a
// queue, a negedge monitor pops and compares them, including the 1-cycle-late status flags.
module tb_alu_exec_unit;

    typedef struct packed {
        logic        rst;
        logic [2:0]  g;
        logic [31:0] r;
        logic        z;
        logic        v;
        logic        n;
        logic [31:0] p4;
        logic [31:0] bt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  aluop;
    logic [3:0]  funct;
    logic [5:0]  opcode;
    logic [31:0] a, b, pc;
    logic [15:0] imm16;
    logic [2:0]  gout;
    logic [31:0] result, pc_plus4, branch_target;
    logic        zout, vout, nout, v_flag, z_flag, n_flag;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   stim_done = 1'b0;

    always #5 clk = ~clk;

    alu_exec_unit dut (
        .clk(clk), .reset(reset), .aluop(aluop), .funct(funct), .opcode(opcode),
        .a(a), .b(b), .pc(pc), .imm16(imm16), .gout(gout), .result(result),
        .zout(zout), .vout(vout), .nout(nout), .pc_plus4(pc_plus4),
        .branch_target(branch_target), .v_flag(v_flag), .z_flag(z_flag), .n_flag(n_flag)
    );

    // Reference model written from the operation tables with wide signed arithmetic.
    function automatic exp_t model(input logic rst, input logic [1:0] op, input logic [3:0] fn,
                                   input logic [5:0] oc, input logic [31:0] xa,
                                   input logic [31:0] xb, input logic [31:0] xpc,
                                   input logic [15:0] im);
        exp_t   e;
        string  name;
        longint sa, sb, wide;
        name = "add";
        case (op)
            2'd0: name = "add";
            2'd1: name = "sub";
            2'd2: begin
                case (fn)
                    4'd2:  name = "sub";
                    4'd4:  name = "and";
                    4'd5:  name = "or";
                    4'd10: name = "slt";
`ifdef ALU_NOR_EN
                    4'd7:  name = "nor";
`endif
                    default: name = "add";
                endcase
            end
            default: begin
                if (oc == 6'd13) name = "or";
                else if (oc == 6'd12) name = "and";
                else name = "add";
            end
        endcase
        sa = longint'($signed(xa));
        sb = longint'($signed(xb));
        e.rst = rst;
        e.v = 1'b0;
        e.g = 3'd2;
        e.r = 32'h0;
        if (name == "add" || name == "sub") begin
            wide = (name == "add") ? sa + sb : sa - sb;
            e.g  = (name == "add") ? 3'd2 : 3'd6;
            e.r  = wide[31:0];
            e.v  = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
        end else if (name == "and") begin
            e.g = 3'd0;
            e.r = xa & xb;
        end else if (name == "or") begin
            e.g = 3'd1;
            e.r = xa | xb;
        end else if (name == "slt") begin
            e.g = 3'd7;
            e.r = (sa < sb) ? 32'd1 : 32'd0;
        end else begin
            e.g = 3'd4;
            e.r = ~(xa | xb);
        end
        e.z = (e.r == 32'h0);
        e.n = e.r[31];
        wide = longint'(xpc) + 4;
        e.p4 = wide[31:0];
        wide = wide + longint'($signed(im)) * 4;
        e.bt = wide[31:0];
        return e;
    endfunction

    task automatic drive(input logic rst, input logic [1:0] op, input logic [3:0] fn,
                         input logic [5:0] oc, input logic [31:0] xa, input logic [31:0] xb,
                         input logic [31:0] xpc, input logic [15:0] im);
        @(posedge clk);
        #1;
        reset = rst; aluop = op; funct = fn; opcode = oc;
        a = xa; b = xb; pc = xpc; imm16 = im;
        q.push_back(model(rst, op, fn, oc, xa, xb, xpc, im));
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 5))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: combinational outputs against this cycle's entry, flags against the last one.
    initial begin
        exp_t e;
        logic [2:0] exp_flags;
        bit flags_known;
        flags_known = 1'b0;
        exp_flags = 3'b000;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (flags_known) check("flags", {29'b0, v_flag, z_flag, n_flag},
                                       {29'b0, exp_flags});
                check("gout", {29'b0, gout}, {29'b0, e.g});
                check("result", result, e.r);
                check("zvn", {29'b0, zout, vout, nout}, {29'b0, e.z, e.v, e.n});
                check("pc_plus4", pc_plus4, e.p4);
                check("branch_target", branch_target, e.bt);
                exp_flags = e.rst ? 3'b000 : {e.v, e.z, e.n};
                flags_known = 1'b1;
            end
        end
    end

    initial begin
        int guard;
        drive(1'b1, 2'b00, 4'h0, 6'h0, 32'h0, 32'h0, 32'h0, 16'h0);
        drive(1'b1, 2'b00, 4'h0, 6'h0, 32'h1, 32'h2, 32'h100, 16'h1);
        // Overflowing add, then reset while vout=1, then flags resume.
        drive(1'b0, 2'b10, 4'b0000, 6'h0, 32'h7FFF_FFFF, 32'h1, 32'h0, 16'h0);
        drive(1'b0, 2'b10, 4'b0000, 6'h0, 32'h7FFF_FFFF, 32'h1, 32'h0, 16'h0);
        drive(1'b1, 2'b10, 4'b0000, 6'h0, 32'h7FFF_FFFF, 32'h1, 32'h0, 16'h0);
        drive(1'b0, 2'b10, 4'b0000, 6'h0, 32'h7FFF_FFFF, 32'h1, 32'h0, 16'h0);
        drive(1'b0, 2'b01, 4'h0, 6'h0, 32'h5, 32'h5, 32'h0, 16'h0);
        drive(1'b0, 2'b10, 4'b1010, 6'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 16'h0);
        drive(1'b0, 2'b10, 4'b1010, 6'h0, 32'h1, 32'hFFFF_FFFF, 32'h0, 16'h0);
        drive(1'b0, 2'b10, 4'b1010, 6'h0, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 16'h0);
        drive(1'b0, 2'b00, 4'h0, 6'h0, 32'h0, 32'h0, 32'h10, 16'hFFFE);
        drive(1'b0, 2'b00, 4'h0, 6'h0, 32'h0, 32'h0, 32'hFFFF_FFFC, 16'h7FFF);
        drive(1'b0, 2'b11, 4'h0, 6'b001101, 32'hF0F0_0000, 32'h0000_FFFF, 32'h0, 16'h0);
        drive(1'b0, 2'b11, 4'h0, 6'b001100, 32'hF0F0_00FF, 32'h0000_FFFF, 32'h0, 16'h0);
        drive(1'b0, 2'b11, 4'h0, 6'b100011, 32'h8000_0000, 32'h8000_0000, 32'h0, 16'h0);
        drive(1'b0, 2'b10, 4'b0111, 6'h0, 32'h0, 32'h0000_00FF, 32'h0, 16'h0);
        drive(1'b0, 2'b10, 4'b0010, 6'h0, 32'h8000_0000, 32'h1, 32'h0, 16'h0);
        drive(1'b0, 2'b10, 4'b0100, 6'h0, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0, 16'h0);
        drive(1'b0, 2'b10, 4'b0101, 6'h0, 32'h0, 32'h0, 32'h0, 16'h8000);
        drive(1'b0, 2'b10, 4'b1111, 6'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 16'h0);
        for (int i = 0; i < 400; i++) begin
            logic [3:0] fn;
            logic [5:0] oc;
            fn = ($urandom_range(0, 3) == 0) ? 4'($urandom) :
                 (($urandom_range(0, 1) == 0) ? 4'b1010 : 4'($urandom_range(0, 7)));
            oc = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'(12 + $urandom_range(0, 1));
            drive(($urandom_range(0, 15) == 0), 2'($urandom), fn, oc, pick32(), pick32(),
                  pick32(), 16'($urandom));
        end
        drive(1'b0, 2'b00, 4'h0, 6'h0, 32'h0, 32'h0, 32'h0, 16'h0);
        guard = 0;
        while (q.size() > 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        @(posedge clk);
        stim_done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
